// File: rtl/spi_mem_param.sv
// SPI mode-0 slave in front of a 2**ADDR_W x DATA_W register file: address, R/W bit, then data.
// Define SPI_MEM_BURST_EN for address auto-increment bursts; without it, one word per chip-select.
module spi_mem_param #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 7,
  parameter int SCLK_MIN_HALF = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso,
  output logic       miso_oe,
  output logic       busy,
  output logic [2:0] state
);

  localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DEPTH   = 2 ** ADDR_W;

  // Two sync flops plus one edge-detect stage need at least three clk per sclk half-period.
  if (SCLK_MIN_HALF < 3) begin : g_half_check
    $error("spi_mem_param: SCLK_MIN_HALF must be at least 3");
  end

`ifdef SPI_MEM_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    RD_LOAD  = 3'd2,
    RD_SHIFT = 3'd3,
    WR_SHIFT = 3'd4,
    WR_STORE = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t              st, st_n;
  logic [2:0]          sclk_s;
  logic [2:0]          cs_s;
  logic [1:0]          mosi_s;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   shreg;
  logic                miso_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic sclk_rise, sclk_fall, cs_high, cs_fall, mosi_bit;
  logic last_addr_bit, last_data_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk_pin};
      cs_s   <= {cs_s[1:0], cs_pin};
      mosi_s <= {mosi_s[0], mosi_pin};
    end
  end

  // Index 1 is the synchronized level; index 2 is only the edge-detect history.
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign cs_high   = cs_s[1];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign mosi_bit  = mosi_s[1];

  assign last_addr_bit = (bit_cnt == CNT_W'(ADDR_W));
  assign last_data_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    st_n = st;
    case (st)
      IDLE:     if (cs_fall) st_n = GET_ADDR;
      GET_ADDR: if (sclk_rise && last_addr_bit) st_n = mosi_bit ? RD_LOAD : WR_SHIFT;
      RD_LOAD:  st_n = RD_SHIFT;
      RD_SHIFT: if (sclk_rise && last_data_bit) st_n = BURST_EN ? RD_LOAD : DONE;
      WR_SHIFT: if (sclk_rise && last_data_bit) st_n = WR_STORE;
      WR_STORE: st_n = BURST_EN ? WR_SHIFT : DONE;
      DONE:     st_n = DONE;
      default:  st_n = IDLE;
    endcase
    if (cs_high) st_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= IDLE;
      bit_cnt <= '0;
      addr_q  <= '0;
      shreg   <= '0;
      miso_q  <= 1'b0;
      miso_oe <= 1'b0;
    end else begin
      st      <= st_n;
      miso_oe <= (st_n == RD_SHIFT);
      if (st_n == IDLE) begin
        // Abort path: any partially shifted word is simply abandoned.
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (st)
          GET_ADDR: begin
            if (sclk_rise) begin
              if (last_addr_bit) begin
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                addr_q  <= {addr_q[ADDR_W-2:0], mosi_bit};
              end
            end
          end
          RD_LOAD: begin
            shreg  <= mem[addr_q];
            miso_q <= 1'b0;
          end
          RD_SHIFT: begin
            if (sclk_fall) begin
              miso_q <= shreg[DATA_W-1];
              shreg  <= {shreg[DATA_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
              if (last_data_bit) begin
                bit_cnt <= '0;
`ifdef SPI_MEM_BURST_EN
                addr_q  <= addr_q + ADDR_W'(1);
`endif
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          WR_SHIFT: begin
            if (sclk_rise) begin
              shreg   <= {shreg[DATA_W-2:0], mosi_bit};
              bit_cnt <= last_data_bit ? '0 : bit_cnt + CNT_W'(1);
            end
          end
          WR_STORE: begin
`ifdef SPI_MEM_BURST_EN
            addr_q <= addr_q + ADDR_W'(1);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Memory is never reset; the store happens even if cs rises during WR_STORE.
  always_ff @(posedge clk) begin
    if (!reset && st == WR_STORE) mem[addr_q] <= shreg;
  end

  assign miso  = miso_q & miso_oe;
  assign busy  = (st != IDLE);
  assign state = st;

endmodule

// File: doc/spi_mem_param.md
SPI_MEM_PARAM -- requirements
Module: spi_mem_param

Interface
REQ-001 Parameter DATA_W, default 8: memory word width and SPI data-frame length in bits.
REQ-002 Parameter ADDR_W, default 7: address width; memory depth is 2**ADDR_W words.
REQ-003 Parameter SCLK_MIN_HALF, default 6: minimum sclk half-period in clk cycles the block is guaranteed to support.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sclk_pin  input  1  raw SPI clock, asynchronous to clk.
REQ-007 cs_pin  input  1  raw SPI chip select, active low, asynchronous.
REQ-008 mosi_pin  input  1  raw SPI master-out data, asynchronous.
REQ-009 miso  output  1  SPI master-in data.
REQ-010 miso_oe  output  1  high while miso is to be driven; the top level builds the tristate from it.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 state  output  3  current FSM state encoding, for the debug LEDs.

Function
REQ-013 Each raw pin SHALL pass through a 2-flop synchronizer; sclk SHALL additionally get one-cycle rise/fall pulses from a third registered stage.
REQ-014 SPI mode 0 applies: MOSI is sampled on sclk rise, MISO changes on sclk fall, and frames are sent MSB first.
REQ-015 Transaction format: ADDR_W address bits, then 1 R/W bit (1 = read), then DATA_W data bits.
REQ-016 FSM states and encodings: IDLE=0, GET_ADDR=1, RD_LOAD=2, RD_SHIFT=3, WR_SHIFT=4, WR_STORE=5, DONE=6.
REQ-017 IDLE -> GET_ADDR on the synchronized cs falling.
REQ-018 GET_ADDR: shift one bit per sclk rise; after ADDR_W+1 rises, latch the address and go to RD_LOAD if R/W=1, else WR_SHIFT.
REQ-019 RD_LOAD: synchronous memory read (1 clk), load the word into the shift register, go to RD_SHIFT; total time from the final address rise to the load SHALL be at most 4 clk.
REQ-020 RD_SHIFT: assert miso_oe; on each sclk fall, drive the next bit, starting with the MSB on the first fall after the R/W bit.
REQ-021 After DATA_W rises in RD_SHIFT, go to RD_LOAD with the address incremented when burst is enabled, else to DONE.
REQ-022 WR_SHIFT: shift in DATA_W bits on sclk rises, then go to WR_STORE.
REQ-023 WR_STORE: write the word to mem[addr] in exactly one clk, then go to WR_SHIFT with the address incremented when burst is enabled, else to DONE.
REQ-024 DONE: ignore sclk; miso_oe stays low.
REQ-025 Address increment SHALL wrap from 2**ADDR_W-1 to 0.
REQ-026 cs high in any state SHALL force IDLE on the next clk.
REQ-027 On cs high, a partially shifted write word SHALL be discarded, with no memory write.
REQ-028 If cs rises in the same cycle as WR_STORE, the store completes.
REQ-029 miso SHALL be 0 whenever miso_oe is low.
REQ-030 An sclk edge arriving while cs is high SHALL have no effect.

Reset
REQ-031 While reset is high, the state goes to IDLE.
REQ-032 Reset clears miso, miso_oe, busy, the bit counter, the address register, the shift register and the synchronizer flops to 0.
REQ-033 Reset does not alter memory contents.
REQ-034 Reset mid-transaction SHALL abort with no memory write.
REQ-035 After reset deasserts, a new transaction requires a fresh cs falling edge.

Configuration
REQ-036 Macro SPI_MEM_BURST_EN defined: the auto-incrementing burst of REQ-021 and REQ-023 continues for as long as cs stays low.
REQ-037 SPI_MEM_BURST_EN undefined: exactly one data word per transaction, then DONE until cs rises, and no increment logic is synthesized.

Verification
REQ-038 Defaults, half-period 8 clk: write addr 0x05 data 0xA5, then read addr 0x05 -> MISO returns 0xA5 MSB first, and miso_oe is high for exactly the 8 data bits.
REQ-039 Burst enabled: write addr 0x7F with 0x11, 0x22 in one cs-low window -> mem[0x7F]=0x11 and mem[0x00]=0x22 (wrap); burst read from 0x7F returns 0x11, 0x22.
REQ-040 Burst disabled: same stimulus as REQ-039 -> only mem[0x7F]=0x11; the second word is ignored, state=6 until cs rises, and mem[0x00] is unchanged.
REQ-041 Write addr 0x10 with cs raised after 5 data bits -> mem[0x10] keeps its prior value and state returns to 0 one clk after the synchronized cs rise.
REQ-042 Reset asserted during the RD_SHIFT of a read -> on the next clk, miso=0, miso_oe=0, busy=0, state=0; memory contents are unchanged.
REQ-043 Parameters DATA_W=16, ADDR_W=4: write addr 0xF data 0xBEEF, then read -> returns 0xBEEF over 16 sclk cycles.
